// File: rtl/prn_pkg.sv
// Shared types and constants for the PRN arbiter slice.
// The optional PRN_ARB_STATS_EN build uses STAT_W for its counters.
package prn_pkg;

   typedef enum logic {ST_WARMUP, ST_SERVE} state_t;

   // Matches the lfsr reset value; slice down to the lfsr WIDTH where used.
   localparam logic [63:0] PRN_SEED = '1;

   localparam int STAT_W = 32;

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index after pointer, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter
   import prn_pkg::*;
#(
   parameter int N = 4,
   localparam int PW = clog2_min1(N)
)
(
   input  logic [N-1:0]  eligible,
   input  logic [PW-1:0] pointer,
   input  logic          enable,
   output logic [N-1:0]  winner,
   output logic          valid
);

   logic [PW-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      // k=N revisits the pointer itself last, so a lone requester still wins.
      for (int k = 1; k <= N; k++) begin
         idx = PW'((int'(pointer) + k) % N);
         if (enable && !valid && eligible[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prn_arbiter.sv
// Round-robin sharing of one lfsr PRN stream between NUM_REQ requesters.
// Define PRN_ARB_STATS_EN to add the stat_grants / stat_wait counter outputs.
module prn_arbiter
   import prn_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int NUM_REQ       = 4,
   parameter int WARMUP_CYCLES = 8
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               hold,
   input  logic [WIDTH-1:0]   prn_in,
   output logic               lfsr_enable,
   output logic [NUM_REQ-1:0] gnt,
   output logic [WIDTH-1:0]   prn_out,
   output logic               ready
`ifdef PRN_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]  stat_grants,
   output logic [STAT_W-1:0]  stat_wait
`endif
);

   localparam int PW = clog2_min1(NUM_REQ);
   localparam int CW = clog2_min1(WARMUP_CYCLES + 1);

   state_t             state_reg;
   logic [CW-1:0]      warm_cnt_reg;
   logic [PW-1:0]      ptr_reg;
   logic [NUM_REQ-1:0] gnt_reg;
   logic [WIDTH-1:0]   prn_reg;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] winner;
   logic               win_valid;
   logic               arb_en;
   logic [PW-1:0]      win_idx;

   // Masking the live grant stops a requester that has not yet dropped req from winning twice.
   assign eligible = req & ~gnt_reg;
   assign arb_en   = !reset && (state_reg == ST_SERVE) && !hold;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .eligible (eligible),
      .pointer  (ptr_reg),
      .enable   (arb_en),
      .winner   (winner),
      .valid    (win_valid)
   );

   always_comb begin
      win_idx = ptr_reg;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            win_idx = PW'(i);
         end
      end
   end

   assign lfsr_enable = !reset &&
                        (((state_reg == ST_WARMUP) && (warm_cnt_reg != '0)) || win_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_WARMUP;
         warm_cnt_reg <= CW'(WARMUP_CYCLES);
         ptr_reg      <= PW'(NUM_REQ - 1);
         gnt_reg      <= '0;
         prn_reg      <= '0;
      end else begin
         gnt_reg <= '0;
         case (state_reg)
            ST_WARMUP: begin
               if (warm_cnt_reg != '0) begin
                  warm_cnt_reg <= warm_cnt_reg - CW'(1);
               end
               // Leave on the last stepping cycle, or at once when no warmup is configured.
               if (warm_cnt_reg <= CW'(1)) begin
                  state_reg <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (win_valid) begin
                  gnt_reg <= winner;
                  prn_reg <= prn_in;
                  ptr_reg <= win_idx;
               end
            end
            default: state_reg <= ST_WARMUP;
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign prn_out = prn_reg;
   assign ready   = (state_reg == ST_SERVE);

`ifdef PRN_ARB_STATS_EN
   logic [STAT_W-1:0] stat_grants_reg;
   logic [STAT_W-1:0] stat_wait_reg;

   // With a work-conserving picker, stat_wait only moves if a cycle has eligible requesters but no winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_grants_reg <= '0;
         stat_wait_reg   <= '0;
      end else begin
         if (win_valid) begin
            stat_grants_reg <= stat_grants_reg + STAT_W'(1);
         end
         if ((state_reg == ST_SERVE) && (|eligible) && !hold && !win_valid &&
             (stat_wait_reg != '1)) begin
            stat_wait_reg <= stat_wait_reg + STAT_W'(1);
         end
      end
   end

   assign stat_grants = stat_grants_reg;
   assign stat_wait   = stat_wait_reg;
`endif

endmodule

// File: tb/tb_prn_arbiter.sv
// Directed bench: two arbiters (warmup 0 and 8), each fed by a local lfsr model.
// Stats checks are compiled in when PRN_ARB_STATS_EN is defined.
module tb_prn_arbiter;
   import prn_pkg::*;

   typedef struct {
      logic [3:0]  req;
      logic        hold;
      logic        en;
      logic [3:0]  gnt;
      logic [15:0] prn;
      logic        ready;
   } vec_t;

   logic        clk;
   logic        rst0, rst8;
   logic [3:0]  req0, req8;
   logic        hold0, hold8;
   logic [15:0] lfsr0, lfsr8;
   logic        en0, en8;
   logic [3:0]  gnt0, gnt8;
   logic [15:0] prn0, prn8;
   logic        ready0, ready8;
`ifdef PRN_ARB_STATS_EN
   logic [31:0] sg0, sw0, sg8, sw8;
`endif

   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], 1'b0} ^ (v[15] ? 16'h002D : 16'h0000);
   endfunction

   always_ff @(posedge clk) begin
      if (rst0)     lfsr0 <= PRN_SEED[15:0];
      else if (en0) lfsr0 <= lfsr_step(lfsr0);
      if (rst8)     lfsr8 <= PRN_SEED[15:0];
      else if (en8) lfsr8 <= lfsr_step(lfsr8);
   end

   prn_arbiter #(.WIDTH(16), .NUM_REQ(4), .WARMUP_CYCLES(0)) dut0 (
      .clk(clk), .reset(rst0), .req(req0), .hold(hold0), .prn_in(lfsr0),
      .lfsr_enable(en0), .gnt(gnt0), .prn_out(prn0), .ready(ready0)
`ifdef PRN_ARB_STATS_EN
      , .stat_grants(sg0), .stat_wait(sw0)
`endif
   );

   prn_arbiter #(.WIDTH(16), .NUM_REQ(4), .WARMUP_CYCLES(8)) dut8 (
      .clk(clk), .reset(rst8), .req(req8), .hold(hold8), .prn_in(lfsr8),
      .lfsr_enable(en8), .gnt(gnt8), .prn_out(prn8), .ready(ready8)
`ifdef PRN_ARB_STATS_EN
      , .stat_grants(sg8), .stat_wait(sw8)
`endif
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic add(input logic [3:0] r, input logic h, input logic e,
                      input logic [3:0] g, input logic [15:0] p, input logic rd);
      vec_t v;
      v.req = r; v.hold = h; v.en = e; v.gnt = g; v.prn = p; v.ready = rd;
      vecs.push_back(v);
   endtask

   initial begin
      logic [15:0] exp_prn;
      logic [3:0]  exp_g;
      int          ngr;

      // Warmup of 8 with all four requesting; ready appears after the 8th step.
      for (int i = 0; i < 7; i++) add(4'b1111, 1'b0, 1'b1, 4'b0000, 16'h0000, 1'b0);
      add(4'b1111, 1'b0, 1'b1, 4'b0000, 16'h0000, 1'b1);
      add(4'b1111, 1'b0, 1'b1, 4'b0001, 16'hE41B, 1'b1);
      add(4'b1111, 1'b0, 1'b1, 4'b0010, 16'hC81B, 1'b1);
      add(4'b1111, 1'b0, 1'b1, 4'b0100, 16'h901B, 1'b1);
      add(4'b1111, 1'b0, 1'b1, 4'b1000, 16'h201B, 1'b1);
      add(4'b1111, 1'b0, 1'b1, 4'b0001, 16'h4036, 1'b1);
      // Two requesters held high: strict alternation.
      add(4'b1010, 1'b0, 1'b1, 4'b0010, 16'h806C, 1'b1);
      add(4'b1010, 1'b0, 1'b1, 4'b1000, 16'h00F5, 1'b1);
      add(4'b1010, 1'b0, 1'b1, 4'b0010, 16'h01EA, 1'b1);
      add(4'b1010, 1'b0, 1'b1, 4'b1000, 16'h03D4, 1'b1);
      // Hold freezes grants and stepping; release serves the un-advanced PRN.
      for (int i = 0; i < 5; i++) add(4'b0100, 1'b1, 1'b0, 4'b0000, 16'h0000, 1'b1);
      add(4'b0100, 1'b0, 1'b1, 4'b0100, 16'h07A8, 1'b1);
      add(4'b0000, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b1);
      add(4'b0010, 1'b0, 1'b1, 4'b0010, 16'h0F50, 1'b1);

      rst0 = 1'b1; rst8 = 1'b1;
      req0 = '0; req8 = '0; hold0 = 1'b0; hold8 = 1'b0;
      cyc();
      cyc();
      chk("rst gnt0", 32'(gnt0), 32'h0);
      chk("rst prn0", 32'(prn0), 32'h0);
      chk("rst ready0", 32'(ready0), 32'h0);
      chk("rst gnt8", 32'(gnt8), 32'h0);
      chk("rst prn8", 32'(prn8), 32'h0);
      chk("rst ready8", 32'(ready8), 32'h0);
`ifdef PRN_ARB_STATS_EN
      chk("rst stat_grants", sg8, 32'h0);
      chk("rst stat_wait", sw8, 32'h0);
`endif

      // Zero-warmup arbiter, single requester dropping req on each grant.
      rst0 = 1'b0; req0 = 4'b0001;
      #1 chk("s1 en warm", 32'(en0), 32'h0);
      cyc();
      chk("s1 ready", 32'(ready0), 32'h1);
      chk("s1 no gnt yet", 32'(gnt0), 32'h0);
      #1 chk("s1 en serve", 32'(en0), 32'h1);
      cyc();
      chk("s1 gnt a", 32'(gnt0), 32'h1);
      chk("s1 prn a", 32'(prn0), 32'hFFFF);
      req0 = 4'b0000;
      #1 chk("s1 en idle", 32'(en0), 32'h0);
      cyc();
      chk("s1 idle gnt", 32'(gnt0), 32'h0);
      req0 = 4'b0001;
      cyc();
      chk("s1 gnt b", 32'(gnt0), 32'h1);
      chk("s1 prn b", 32'(prn0), 32'hFFD3);
      req0 = 4'b0000;
      cyc();
      req0 = 4'b0001;
      cyc();
      chk("s1 gnt c", 32'(gnt0), 32'h1);
      chk("s1 prn c", 32'(prn0), 32'hFF8B);
      req0 = 4'b0000;

      // Table-driven run on the warmup-8 arbiter.
      rst8 = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         req8  = vecs[i].req;
         hold8 = vecs[i].hold;
         #1 chk($sformatf("v%0d en", i), 32'(en8), 32'(vecs[i].en));
         cyc();
         chk($sformatf("v%0d gnt", i), 32'(gnt8), 32'(vecs[i].gnt));
         chk($sformatf("v%0d ready", i), 32'(ready8), 32'(vecs[i].ready));
         if (vecs[i].gnt != 4'b0000) begin
            chk($sformatf("v%0d prn", i), 32'(prn8), 32'(vecs[i].prn));
         end
      end

      // Reset the cycle after gnt[1]: grant dropped, warmup restarts from the seed.
      rst8 = 1'b1; req8 = 4'b0000; hold8 = 1'b0;
      cyc();
      chk("s5 gnt", 32'(gnt8), 32'h0);
      chk("s5 ready", 32'(ready8), 32'h0);
      chk("s5 prn", 32'(prn8), 32'h0);
`ifdef PRN_ARB_STATS_EN
      chk("s5 stat_grants rst", sg8, 32'h0);
      chk("s5 stat_wait rst", sw8, 32'h0);
`endif
      rst8 = 1'b0; req8 = 4'b0111;
      exp_prn = 16'hE41B;
      ngr = 0;
      for (int c = 0; c < 200 && ngr < 10; c++) begin
         cyc();
         if (gnt8 != 4'b0000) begin
            exp_g = '0;
            exp_g[ngr % 3] = 1'b1;
            chk($sformatf("s6 g%0d gnt", ngr), 32'(gnt8), 32'(exp_g));
            chk($sformatf("s6 g%0d prn", ngr), 32'(prn8), 32'(exp_prn));
            exp_prn = lfsr_step(exp_prn);
            ngr++;
         end
      end
      chk("s6 grant count", 32'(ngr), 32'd10);
`ifdef PRN_ARB_STATS_EN
      chk("s6 stat_grants", sg8, 32'd10);
      chk("s6 stat_wait", sw8, 32'd0);
`endif
      req8 = 4'b0000;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
